// File: rtl/regfile_debug_pkg.sv
// Shared types and constants for the register-file debug port.
package regfile_debug_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        LOAD = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic OP_DUMP = 1'b0;
    localparam logic OP_LOAD = 1'b1;

endpackage

// File: rtl/regfile_debug_ptr.sv
// Wrapping register-address pointer shared by the dump and load walks.
module regfile_debug_ptr #(
    parameter int ADDRESS_LEN = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [ADDRESS_LEN-1:0] load_first,
    input  logic [ADDRESS_LEN-1:0] load_last,
    input  logic                   inc,
    output logic [ADDRESS_LEN-1:0] ptr,
    output logic                   at_end
);

    logic [ADDRESS_LEN-1:0] end_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            end_q <= '0;
        end else if (load) begin
            ptr   <= load_first;
            end_q <= load_last;
        end else if (inc) begin
            // Natural overflow gives the modulo-2**ADDRESS_LEN wrap.
            ptr <= ptr + 1'b1;
        end
    end

    assign at_end = (ptr == end_q);

endmodule

// File: rtl/regfile_debug_port.sv
// Debug initiator: dumps a register range as a stream or loads one from a stream.
module regfile_debug_port
    import regfile_debug_pkg::*;
#(
    parameter int ADDRESS_LEN = 5,
    parameter int N           = 64,
    parameter bit PROTECT_X0  = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_op,
    input  logic [ADDRESS_LEN-1:0] cmd_first,
    input  logic [ADDRESS_LEN-1:0] cmd_last,
    input  logic                   abort,
    output logic [ADDRESS_LEN-1:0] rf_rd_addr,
    input  logic [N-1:0]           rf_rd_data,
    output logic                   rf_wr_en,
    output logic [ADDRESS_LEN-1:0] rf_wr_addr,
    output logic [N-1:0]           rf_wr_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N-1:0]           out_data,
    output logic [ADDRESS_LEN-1:0] out_addr,
    output logic                   out_last,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0]           in_data,
    output logic                   busy,
    output logic                   done
);

    state_e                 state;
    logic [ADDRESS_LEN-1:0] ptr;
    logic                   at_end;
    logic                   ptr_load;
    logic                   ptr_inc;
    logic                   cap;
    logic                   out_hs;
    logic                   in_hs;

    assign cmd_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign in_ready  = (state == LOAD);

    assign ptr_load = cmd_valid && cmd_ready;
    assign out_hs   = out_valid && out_ready;
    assign in_hs    = in_ready && in_valid;
    // Refill the output register when it is empty or draining, but never past the last beat.
    assign cap      = (state == DUMP) && !abort && (!out_valid || (out_ready && !out_last));
    assign ptr_inc  = cap || in_hs;

    assign rf_rd_addr = ptr;
    assign rf_wr_addr = ptr;
    assign rf_wr_data = in_data;
    assign rf_wr_en   = in_hs && !abort && !(PROTECT_X0 && (ptr == '0));

    regfile_debug_ptr #(.ADDRESS_LEN(ADDRESS_LEN)) u_ptr (
        .clk        (clk),
        .rst        (rst),
        .load       (ptr_load),
        .load_first (cmd_first),
        .load_last  (cmd_last),
        .inc        (ptr_inc),
        .ptr        (ptr),
        .at_end     (at_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid)
                        state <= (cmd_op == OP_LOAD) ? LOAD : DUMP;
                end
                DUMP: begin
                    if (abort) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end else if (out_hs && out_last) begin
                        state     <= DONE;
                        out_valid <= 1'b0;
                    end else if (cap) begin
                        out_valid <= 1'b1;
                        out_data  <= rf_rd_data;
                        out_addr  <= ptr;
                        out_last  <= at_end;
                    end
                end
                LOAD: begin
                    if (abort)
                        state <= IDLE;
                    else if (in_hs && at_end)
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_debug_port.sv
module tb_regfile_debug_port;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_op = 1'b0;
    logic [4:0]  cmd_first = '0;
    logic [4:0]  cmd_last = '0;
    logic        abort = 1'b0;
    logic [4:0]  rf_rd_addr;
    logic [63:0] rf_rd_data;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [63:0] rf_wr_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic [4:0]  out_addr;
    logic        out_last;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        busy;
    logic        done;

    logic        init_rf = 1'b1;
    logic [63:0] regs [32];

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    last_hs_cyc = -10;
    int    exp_done = 0;
    beat_t exp_out[$];
    wr_t   exp_wr[$];

    regfile_debug_port #(.ADDRESS_LEN(5), .N(64), .PROTECT_X0(1'b1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_first(cmd_first), .cmd_last(cmd_last), .abort(abort),
        .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file model: reg i preloads to i*0x10.
    always @(posedge clk) begin
        if (init_rf) begin
            for (int i = 0; i < 32; i++) regs[i] <= 64'(i) << 4;
        end else if (rf_wr_en) begin
            regs[rf_wr_addr] <= rf_wr_data;
        end
    end
    assign rf_rd_data = regs[rf_rd_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Dump-stream monitor.
    initial forever begin
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            last_hs_cyc = cyc;
            if (exp_out.size() == 0) begin
                chk("out_unexpected_beat", 64'(out_addr), 64'hFFFF);
            end else begin
                beat_t b;
                b = exp_out.pop_front();
                chk("out_addr", 64'(out_addr), 64'(b.addr));
                chk("out_data", out_data, b.data);
                chk("out_last", 64'(out_last), 64'(b.last));
            end
        end
    end

    // Register-write and load-handshake monitor.
    initial forever begin
        @(negedge clk);
        if (!rst && in_valid && in_ready) last_hs_cyc = cyc;
        if (rf_wr_en) begin
            if (exp_wr.size() == 0) begin
                chk("wr_unexpected", 64'(rf_wr_addr), 64'hFFFF);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                chk("wr_addr", 64'(rf_wr_addr), 64'(w.addr));
                chk("wr_data", rf_wr_data, w.data);
            end
        end
    end

    // Completion monitor: every done pulse must be expected and follow the last handshake by one cycle.
    initial forever begin
        @(negedge clk);
        if (done) begin
            chk("done_expected", 64'(exp_done > 0), 64'd1);
            chk("done_timing", 64'(cyc), 64'(last_hs_cyc + 1));
            if (exp_done > 0) exp_done--;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic issue(input logic op, input logic [4:0] first, input logic [4:0] last);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_first = first; cmd_last = last;
        @(negedge clk);
        chk("cmd_ready_on_issue", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        chk(name, 64'(ok), 64'd1);
    endtask

    task automatic feed(input logic [63:0] d);
        bit ok = 1'b0;
        in_valid = 1'b1; in_data = d;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("feed_accepted", 64'(ok), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic push_beat(input logic [4:0] a, input logic [63:0] d, input logic l);
        beat_t b;
        b.addr = a; b.data = d; b.last = l;
        exp_out.push_back(b);
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [63:0] d);
        wr_t w;
        w.addr = a; w.data = d;
        exp_wr.push_back(w);
    endtask

    initial begin
        int n;
        bit ok;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rf_wr_en", 64'(rf_wr_en), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; init_rf = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("post_rst_done", 64'(done), 64'd0);

        // DUMP 3..6 with ready held high.
        push_beat(5'd3, 64'h30, 1'b0);
        push_beat(5'd4, 64'h40, 1'b0);
        push_beat(5'd5, 64'h50, 1'b0);
        push_beat(5'd6, 64'h60, 1'b1);
        exp_done++;
        out_ready = 1'b1;
        issue(1'b0, 5'd3, 5'd6);
        wait_idle("dump_3_6_idle");

        // DUMP 30..1 wrapping, ready toggling.
        push_beat(5'd30, 64'h1E0, 1'b0);
        push_beat(5'd31, 64'h1F0, 1'b0);
        push_beat(5'd0, 64'h0, 1'b0);
        push_beat(5'd1, 64'h10, 1'b1);
        exp_done++;
        issue(1'b0, 5'd30, 5'd1);
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            out_ready = ~out_ready;
            if (!busy) begin ok = 1'b1; break; end
        end
        chk("dump_wrap_idle", 64'(ok), 64'd1);
        out_ready = 1'b1;

        // LOAD 0..2: addr 0 protected.
        push_wr(5'd1, 64'hB);
        push_wr(5'd2, 64'hC);
        exp_done++;
        issue(1'b1, 5'd0, 5'd2);
        feed(64'hA);
        feed(64'hB);
        feed(64'hC);
        wait_idle("load_0_2_idle");

        // Readback 0..2.
        push_beat(5'd0, 64'h0, 1'b0);
        push_beat(5'd1, 64'hB, 1'b0);
        push_beat(5'd2, 64'hC, 1'b1);
        exp_done++;
        issue(1'b0, 5'd0, 5'd2);
        wait_idle("readback_idle");

        // LOAD 5..5 with a gap; a command pulsed mid-load is ignored.
        push_wr(5'd5, 64'h55);
        exp_done++;
        issue(1'b1, 5'd5, 5'd5);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_first = 5'd9; cmd_last = 5'd9;
        @(negedge clk);
        chk("cmd_ready_in_load", 64'(cmd_ready), 64'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        feed(64'h55);
        wait_idle("load_5_idle");
        repeat (3) @(negedge clk);
        chk("ignored_cmd_busy", 64'(busy), 64'd0);

        // DUMP 0..31, abort after the 10th beat.
        push_beat(5'd0, 64'h0, 1'b0);
        push_beat(5'd1, 64'hB, 1'b0);
        push_beat(5'd2, 64'hC, 1'b0);
        push_beat(5'd3, 64'h30, 1'b0);
        push_beat(5'd4, 64'h40, 1'b0);
        push_beat(5'd5, 64'h55, 1'b0);
        push_beat(5'd6, 64'h60, 1'b0);
        push_beat(5'd7, 64'h70, 1'b0);
        push_beat(5'd8, 64'h80, 1'b0);
        push_beat(5'd9, 64'h90, 1'b0);
        issue(1'b0, 5'd0, 5'd31);
        n = 0;
        for (int k = 0; k < 100 && n < 10; k++) begin
            @(negedge clk);
            if (out_valid && out_ready) n++;
        end
        chk("abort_beats_seen", 64'(n), 64'd10);
        @(posedge clk); #1;
        out_ready = 1'b0; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        out_ready = 1'b1;
        push_beat(5'd7, 64'h70, 1'b0);
        push_beat(5'd8, 64'h80, 1'b1);
        exp_done++;
        issue(1'b0, 5'd7, 5'd8);
        wait_idle("after_abort_idle");

        // Reset in the middle of LOAD 10..12.
        push_wr(5'd10, 64'hAA);
        issue(1'b1, 5'd10, 5'd12);
        feed(64'hAA);
        in_valid = 1'b1; in_data = 64'hBB;
        #1;
        chk("midload_wr_en_before", 64'(rf_wr_en), 64'd1);
        rst = 1'b1;
        #1;
        chk("midload_wr_en_after_rst", 64'(rf_wr_en), 64'd0);
        chk("midload_out_data", out_data, 64'h0);
        chk("midload_in_ready", 64'(in_ready), 64'd0);
        chk("midload_busy", 64'(busy), 64'd0);
        chk("midload_cmd_ready", 64'(cmd_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("midload_release_cmd_ready", 64'(cmd_ready), 64'd1);
        repeat (2) @(negedge clk);
        chk("midload_reg10", regs[10], 64'hAA);
        chk("midload_reg11", regs[11], 64'hB0);

        chk("exp_out_empty", 64'(exp_out.size()), 64'd0);
        chk("exp_wr_empty", 64'(exp_wr.size()), 64'd0);
        chk("exp_done_zero", 64'(exp_done), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
